// File: rtl/branch_issue_queue.sv
// Collapsing reservation station for branch ops: snoops the CDB, issues the oldest fully-ready entry.
// Issue is combinational from registered state (dispatch/CDB -> issue >= 1 cycle); a full queue refuses dispatch; flush clears everything.
module branch_issue_queue #(
    parameter int ENTRIES = 4,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [3:0]                     disp_opcode,
    input  logic [TAG_W-1:0]               disp_rob,
    input  logic                           disp_t_rdy,
    input  logic                           disp_a_rdy,
    input  logic                           disp_b_rdy,
    input  logic [TAG_W-1:0]               disp_t_tag,
    input  logic [TAG_W-1:0]               disp_a_tag,
    input  logic [TAG_W-1:0]               disp_b_tag,
    input  logic [DATA_W-1:0]              disp_t_val,
    input  logic [DATA_W-1:0]              disp_a_val,
    input  logic [DATA_W-1:0]              disp_b_val,
    input  logic                           cdb_valid,
    input  logic [TAG_W-1:0]               cdb_tag,
    input  logic [DATA_W-1:0]              cdb_data,
    output logic                           iss_valid,
    input  logic                           iss_ready,
    output logic [3:0]                     iss_opcode,
    output logic [TAG_W-1:0]               iss_rob,
    output logic [DATA_W-1:0]              iss_vt,
    output logic [DATA_W-1:0]              iss_va,
    output logic [DATA_W-1:0]              iss_vb,
    input  logic                           flush,
    output logic [$clog2(ENTRIES+1)-1:0]   count
);
    localparam int CNT_W = $clog2(ENTRIES+1);

    // Operand index 0 = target, 1 = compare a, 2 = compare b.
    typedef struct packed {
        logic                   vld;
        logic [3:0]             op;
        logic [TAG_W-1:0]       rob;
        logic [2:0]             rdy;
        logic [2:0][TAG_W-1:0]  tag;
        logic [2:0][DATA_W-1:0] val;
    } entry_t;

    entry_t [ENTRIES-1:0] ent_q, ent_d;
    entry_t [ENTRIES:0]   cap;
    entry_t               disp_ent;
    logic [CNT_W-1:0]     count_q, count_d, count_after;
    logic [ENTRIES-1:0]   shift;
    logic                 any_rdy;
    logic                 iss_fire;
    logic                 disp_fire;

    function automatic entry_t snoop(input entry_t e, input logic cv,
                                     input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd);
        entry_t r;
        r = e;
        for (int k = 0; k < 3; k++) begin
            if (cv && r.vld && !r.rdy[k] && r.tag[k] == ct) begin
                r.rdy[k] = 1'b1;
                r.val[k] = cd;
            end
        end
        return r;
    endfunction

    assign disp_ready = (count_q < CNT_W'(ENTRIES)) && rst_n && !flush;
    assign iss_valid  = any_rdy && !flush && rst_n;
    assign iss_fire   = iss_valid && iss_ready;
    assign disp_fire  = disp_valid && disp_ready;
    assign count      = count_q;

    // Oldest-ready select; shift marks the issuing slot and everything younger.
    always_comb begin : sel_blk
        logic seen;
        seen       = 1'b0;
        shift      = '0;
        iss_opcode = '0;
        iss_rob    = '0;
        iss_vt     = '0;
        iss_va     = '0;
        iss_vb     = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!seen && ent_q[i].vld && (&ent_q[i].rdy)) begin
                seen       = 1'b1;
                iss_opcode = ent_q[i].op;
                iss_rob    = ent_q[i].rob;
                iss_vt     = ent_q[i].val[0];
                iss_va     = ent_q[i].val[1];
                iss_vb     = ent_q[i].val[2];
            end
            shift[i] = seen;
        end
        any_rdy = seen;
    end

    always_comb begin
        disp_ent     = '0;
        disp_ent.vld = 1'b1;
        disp_ent.op  = disp_opcode;
        disp_ent.rob = disp_rob;
        disp_ent.rdy = {disp_b_rdy, disp_a_rdy, disp_t_rdy};
        disp_ent.tag = {disp_b_tag, disp_a_tag, disp_t_tag};
        disp_ent.val = {disp_b_val, disp_a_val, disp_t_val};
        disp_ent     = snoop(disp_ent, cdb_valid, cdb_tag, cdb_data);
    end

    // Capture first, then collapse, so a snooped operand follows its entry down.
    always_comb begin
        cap         = '0;
        ent_d       = '0;
        count_d     = '0;
        count_after = count_q - CNT_W'(iss_fire);
        for (int i = 0; i < ENTRIES; i++) begin
            cap[i] = snoop(ent_q[i], cdb_valid, cdb_tag, cdb_data);
        end
        if (!flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_d[i] = (iss_fire && shift[i]) ? cap[i+1] : cap[i];
            end
            for (int i = 0; i < ENTRIES; i++) begin
                if (disp_fire && count_after == CNT_W'(i)) begin
                    ent_d[i] = disp_ent;
                end
            end
            count_d = count_after + CNT_W'(disp_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_q   <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_branch_issue_queue.sv
// Self-checking bench for branch_issue_queue: directed table, corner sequences, random vs queue model.
module tb_branch_issue_queue;
    logic        clk;
    logic        rst_n;
    logic        disp_valid, disp_ready;
    logic [3:0]  disp_opcode, disp_rob;
    logic        disp_t_rdy, disp_a_rdy, disp_b_rdy;
    logic [3:0]  disp_t_tag, disp_a_tag, disp_b_tag;
    logic [15:0] disp_t_val, disp_a_val, disp_b_val;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        iss_valid, iss_ready;
    logic [3:0]  iss_opcode, iss_rob;
    logic [15:0] iss_vt, iss_va, iss_vb;
    logic        flush;
    logic [2:0]  count;

    int nvec  = 0;
    int nfail = 0;

    branch_issue_queue #(.ENTRIES(4), .DATA_W(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_rob(disp_rob),
        .disp_t_rdy(disp_t_rdy), .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy),
        .disp_t_tag(disp_t_tag), .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag),
        .disp_t_val(disp_t_val), .disp_a_val(disp_a_val), .disp_b_val(disp_b_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_opcode(iss_opcode), .iss_rob(iss_rob),
        .iss_vt(iss_vt), .iss_va(iss_va), .iss_vb(iss_vb),
        .flush(flush), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: program-order list of waiting branches.
    typedef struct packed {
        logic [3:0]       op;
        logic [3:0]       rob;
        logic [2:0]       rdy;
        logic [2:0][3:0]  tag;
        logic [2:0][15:0] val;
    } ment_t;
    ment_t mq[$];

    typedef struct {
        logic       rst, dv;
        logic [3:0] op, rob;
        logic       ardy;
        logic [3:0] atag;
        logic [15:0] va;
        logic       cv;
        logic [3:0] ctag;
        logic [15:0] cdat;
        logic       ir, fl;
        int         e_cnt;
        logic       e_drdy, e_ivld;
        logic [3:0] e_rob;
        logic [15:0] e_va;
    } vec_t;
    vec_t tbl[16];

    function automatic vec_t mk(logic rst, logic dv, logic [3:0] op, logic [3:0] rob,
                                logic ardy, logic [3:0] atag, logic [15:0] va,
                                logic cv, logic [3:0] ctag, logic [15:0] cdat,
                                logic ir, logic fl, int e_cnt, logic e_drdy,
                                logic e_ivld, logic [3:0] e_rob, logic [15:0] e_va);
        vec_t v;
        v.rst = rst; v.dv = dv; v.op = op; v.rob = rob; v.ardy = ardy; v.atag = atag;
        v.va = va; v.cv = cv; v.ctag = ctag; v.cdat = cdat; v.ir = ir; v.fl = fl;
        v.e_cnt = e_cnt; v.e_drdy = e_drdy; v.e_ivld = e_ivld; v.e_rob = e_rob; v.e_va = e_va;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_disp(input logic dv, input logic [3:0] op, input logic [3:0] rob,
                            input logic ardy, input logic [3:0] atag, input logic [15:0] va);
        disp_valid = dv; disp_opcode = op; disp_rob = rob;
        disp_t_rdy = 1'b1; disp_t_tag = 4'd0; disp_t_val = 16'h0040;
        disp_a_rdy = ardy; disp_a_tag = atag; disp_a_val = va;
        disp_b_rdy = 1'b1; disp_b_tag = 4'd0; disp_b_val = 16'h0000;
    endtask

    task automatic set_cdb(input logic cv, input logic [3:0] ct, input logic [15:0] cd);
        cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
    endtask

    // Called just after a falling edge with inputs applied; checks outputs, advances model and clock.
    task automatic cycle();
        int    sel;
        logic  e_ivld, e_drdy;
        ment_t e;
        #1;
        sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].rdy == 3'b111) begin
                sel = i;
                break;
            end
        end
        e_ivld = rst_n && !flush && (sel >= 0);
        e_drdy = rst_n && !flush && (mq.size() < 4);
        chk("count", 32'(count), 32'(mq.size()));
        chk("disp_ready", 32'(disp_ready), 32'(e_drdy));
        chk("iss_valid", 32'(iss_valid), 32'(e_ivld));
        if (e_ivld && iss_valid) begin
            chk("iss_opcode", 32'(iss_opcode), 32'(mq[sel].op));
            chk("iss_rob", 32'(iss_rob), 32'(mq[sel].rob));
            chk("iss_vt", 32'(iss_vt), 32'(mq[sel].val[0]));
            chk("iss_va", 32'(iss_va), 32'(mq[sel].val[1]));
            chk("iss_vb", 32'(iss_vb), 32'(mq[sel].val[2]));
        end
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                for (int k = 0; k < 3; k++) begin
                    if (cdb_valid && !e.rdy[k] && e.tag[k] == cdb_tag) begin
                        e.rdy[k] = 1'b1;
                        e.val[k] = cdb_data;
                    end
                end
                mq[i] = e;
            end
            if (e_ivld && iss_ready) mq.delete(sel);
            if (disp_valid && e_drdy) begin
                e.op  = disp_opcode;
                e.rob = disp_rob;
                e.rdy = {disp_b_rdy, disp_a_rdy, disp_t_rdy};
                e.tag = {disp_b_tag, disp_a_tag, disp_t_tag};
                e.val = {disp_b_val, disp_a_val, disp_t_val};
                for (int k = 0; k < 3; k++) begin
                    if (!e.rdy[k] && cdb_valid && e.tag[k] == cdb_tag) begin
                        e.rdy[k] = 1'b1;
                        e.val[k] = cdb_data;
                    end
                end
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int exp_r[3];
        int exp_v[3];

        //                rst dv op     rob   ardy atag va        cv ctag cdat      ir fl cnt drdy ivld rob  va
        tbl[0]  = mk(1'b0, 0, 4'h0, 4'd0, 1, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 0, 0, 0, 4'd0, 16'h0000);
        tbl[1]  = mk(1'b1, 1, 4'h8, 4'd3, 1, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 0, 1, 0, 4'd0, 16'h0000);
        tbl[2]  = mk(1'b1, 0, 4'h0, 4'd0, 1, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 1, 1, 1, 4'd3, 16'h0000);
        tbl[3]  = mk(1'b1, 1, 4'hA, 4'd1, 0, 4'd7, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 0, 1, 0, 4'd0, 16'h0000);
        tbl[4]  = mk(1'b1, 1, 4'hB, 4'd2, 1, 4'd0, 16'h0005, 0, 4'd0, 16'h0000, 1, 0, 1, 1, 0, 4'd0, 16'h0000);
        tbl[5]  = mk(1'b1, 0, 4'h0, 4'd0, 1, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 2, 1, 1, 4'd2, 16'h0005);
        tbl[6]  = mk(1'b1, 0, 4'h0, 4'd0, 1, 4'd0, 16'h0000, 1, 4'd7, 16'h0009, 1, 0, 1, 1, 0, 4'd0, 16'h0000);
        tbl[7]  = mk(1'b1, 0, 4'h0, 4'd0, 1, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 1, 1, 1, 4'd1, 16'h0009);
        tbl[8]  = mk(1'b1, 1, 4'h9, 4'd4, 0, 4'd6, 16'h0000, 1, 4'd6, 16'h1234, 1, 0, 0, 1, 0, 4'd0, 16'h0000);
        tbl[9]  = mk(1'b1, 0, 4'h0, 4'd0, 1, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 1, 1, 1, 4'd4, 16'h1234);
        tbl[10] = mk(1'b1, 1, 4'hA, 4'd5, 0, 4'd5, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 0, 1, 0, 4'd0, 16'h0000);
        tbl[11] = mk(1'b1, 1, 4'hA, 4'd6, 0, 4'd5, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 1, 1, 0, 4'd0, 16'h0000);
        tbl[12] = mk(1'b1, 1, 4'hA, 4'd7, 0, 4'd5, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 2, 1, 0, 4'd0, 16'h0000);
        tbl[13] = mk(1'b1, 1, 4'h8, 4'd8, 1, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 1, 3, 0, 0, 4'd0, 16'h0000);
        tbl[14] = mk(1'b1, 0, 4'h0, 4'd0, 1, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 0, 1, 0, 4'd0, 16'h0000);
        tbl[15] = mk(1'b0, 0, 4'h0, 4'd0, 1, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 0, 0, 0, 4'd0, 16'h0000);

        rst_n = 1'b0; flush = 1'b0; iss_ready = 1'b0;
        set_disp(1'b0, 4'h0, 4'd0, 1'b1, 4'd0, 16'h0000);
        set_cdb(1'b0, 4'd0, 16'h0000);
        repeat (2) @(negedge clk);

        for (int r = 0; r < 16; r++) begin
            rst_n = tbl[r].rst; flush = tbl[r].fl; iss_ready = tbl[r].ir;
            set_disp(tbl[r].dv, tbl[r].op, tbl[r].rob, tbl[r].ardy, tbl[r].atag, tbl[r].va);
            set_cdb(tbl[r].cv, tbl[r].ctag, tbl[r].cdat);
            #1;
            chk($sformatf("tbl%0d_count", r), 32'(count), 32'(tbl[r].e_cnt));
            chk($sformatf("tbl%0d_disp_ready", r), 32'(disp_ready), 32'(tbl[r].e_drdy));
            chk($sformatf("tbl%0d_iss_valid", r), 32'(iss_valid), 32'(tbl[r].e_ivld));
            if (tbl[r].e_ivld) begin
                chk($sformatf("tbl%0d_iss_rob", r), 32'(iss_rob), 32'(tbl[r].e_rob));
                chk($sformatf("tbl%0d_iss_va", r), 32'(iss_va), 32'(tbl[r].e_va));
            end
            cycle();
        end

        // Fill to capacity with va pending on tag 5, then stall issue.
        rst_n = 1'b1; flush = 1'b0; iss_ready = 1'b0;
        set_cdb(1'b0, 4'd0, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            set_disp(1'b1, 4'hA, 4'(k), 1'b0, 4'd5, 16'h0000);
            cycle();
        end
        set_disp(1'b1, 4'h8, 4'd9, 1'b1, 4'd0, 16'h0000);
        set_cdb(1'b1, 4'd5, 16'h0055);
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        cycle();
        set_disp(1'b0, 4'h0, 4'd0, 1'b1, 4'd0, 16'h0000);
        set_cdb(1'b0, 4'd0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_iss_valid", 32'(iss_valid), 32'd1);
            chk("stall_iss_rob", 32'(iss_rob), 32'd0);
            cycle();
        end
        iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_iss_rob", 32'(iss_rob), 32'(k));
            chk("drain_iss_va", 32'(iss_va), 32'h0055);
            cycle();
        end
        #1;
        chk("drain_count", 32'(count), 32'd0);

        // Same-cycle issue + dispatch + CDB capture on entries that collapse.
        iss_ready = 1'b0;
        set_disp(1'b1, 4'hA, 4'd10, 1'b0, 4'd3, 16'h0000); cycle();
        set_disp(1'b1, 4'hB, 4'd11, 1'b1, 4'd0, 16'h0011); cycle();
        set_disp(1'b1, 4'h9, 4'd12, 1'b0, 4'd3, 16'h0000); cycle();
        set_disp(1'b1, 4'h8, 4'd13, 1'b1, 4'd0, 16'h0013);
        set_cdb(1'b1, 4'd3, 16'h0077);
        iss_ready = 1'b1;
        #1;
        chk("simul_count", 32'(count), 32'd3);
        chk("simul_iss_rob", 32'(iss_rob), 32'd11);
        cycle();
        set_disp(1'b0, 4'h0, 4'd0, 1'b1, 4'd0, 16'h0000);
        set_cdb(1'b0, 4'd0, 16'h0000);
        exp_r = '{10, 12, 13};
        exp_v = '{32'h77, 32'h77, 32'h13};
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("age_count", 32'(count), 32'(3 - k));
            chk("age_iss_rob", 32'(iss_rob), 32'(exp_r[k]));
            chk("age_iss_va", 32'(iss_va), 32'(exp_v[k]));
            cycle();
        end

        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 99) < 2);
            iss_ready = ($urandom_range(0, 9) < 7);
            disp_valid  = ($urandom_range(0, 1) == 1);
            disp_opcode = 4'(8 + $urandom_range(0, 3));
            disp_rob    = 4'($urandom);
            disp_t_rdy  = ($urandom_range(0, 9) < 6);
            disp_a_rdy  = ($urandom_range(0, 9) < 6);
            disp_b_rdy  = ($urandom_range(0, 9) < 6);
            disp_t_tag  = 4'($urandom_range(0, 7));
            disp_a_tag  = 4'($urandom_range(0, 7));
            disp_b_tag  = 4'($urandom_range(0, 7));
            disp_t_val  = 16'($urandom);
            disp_a_val  = 16'($urandom);
            disp_b_val  = 16'($urandom);
            set_cdb(($urandom_range(0, 9) < 4), 4'($urandom_range(0, 7)), 16'($urandom));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
